// File: rtl/pdp8_tt_fifo.sv
// PDP-8 console teleprinter/keyboard: KL8-style IOT decode in front of RX/TX byte FIFOs.
// Latency: io_* outputs are combinational; FIFO and flag effects land on the edge ending F1.
// Backpressure: rx_ready drops while the RX FIFO is full; CPU pushes to a full TX FIFO are dropped and flagged.

module pdp8_tt_fifo_buf #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          push_acc_o,
    output logic          pop_acc_o
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    // A pop on an empty FIFO is ignored; a push into a full FIFO only fits if a pop frees a slot.
    assign pop_acc_o  = pop_i && !empty_o;
    assign push_acc_o = push_i && (!full_o || pop_acc_o);
    assign head_o     = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Occupancy next state: unchanged when push and pop are both accepted.
    always_comb begin
        count_d = count_q;
        if (push_acc_o && !pop_acc_o) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_acc_o && pop_acc_o) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc_o) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_acc_o)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_acc_o) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

module pdp8_tt_fifo #(
    parameter logic [5:0] RX_DEV    = 6'o03,
    parameter logic [5:0] TX_DEV    = 6'o04,
    parameter int         FIFO_AW   = 4,
    parameter int         MARK_BIT7 = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iot,
    input  logic [3:0]         state,
    input  logic [11:0]        mb,
    input  logic [5:0]         io_select,
    input  logic [11:0]        io_data_in,
    output logic [11:0]        io_data_out,
    output logic               io_selected,
    output logic               io_skip,
    output logic               io_interrupt,
    output logic               io_data_avail,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               tx_overflow,
    output logic [FIFO_AW:0]   rx_count,
    output logic [FIFO_AW:0]   tx_count
);
    localparam logic [3:0] F1 = 4'b0001;

    logic       decode, rx_sel, tx_sel, kie, tsk;
    logic       rx_cpu_pop, tx_cpu_push, tx_clr;
    logic       rx_empty, rx_full, rx_flag, rx_push_acc, rx_pop_acc;
    logic       tx_empty, tx_full, tx_push_acc, tx_pop_acc;
    logic [7:0] rx_head, rx_head_mk;
    logic       tx_flag_q, int_en_q, tx_overflow_q, push_pend_q;
    logic       unused_ok;

    assign unused_ok = ^{mb[11:3], rx_push_acc, rx_pop_acc};

    // IOT decode; RX device takes priority if both codes are configured equal.
    assign decode      = iot && (state == F1);
    assign rx_sel      = decode && (io_select == RX_DEV);
    assign tx_sel      = decode && (io_select == TX_DEV) && !rx_sel;
    assign kie         = rx_sel && (mb[2:0] == 3'b101);
    assign tsk         = tx_sel && (mb[2:0] == 3'b101);
    assign rx_cpu_pop  = rx_sel && !kie && mb[1];
    assign tx_cpu_push = tx_sel && !tsk && mb[2];
    assign tx_clr      = tx_sel && !tsk && mb[1];

    pdp8_tt_fifo_buf #(.AW(FIFO_AW)) u_rx (
        .clk(clk), .reset(reset),
        .push_i(rx_valid && rx_ready), .din_i(rx_data), .pop_i(rx_cpu_pop),
        .head_o(rx_head), .empty_o(rx_empty), .full_o(rx_full), .count_o(rx_count),
        .push_acc_o(rx_push_acc), .pop_acc_o(rx_pop_acc)
    );

    pdp8_tt_fifo_buf #(.AW(FIFO_AW)) u_tx (
        .clk(clk), .reset(reset),
        .push_i(tx_cpu_push), .din_i(io_data_in[7:0]), .pop_i(tx_ready),
        .head_o(tx_data), .empty_o(tx_empty), .full_o(tx_full), .count_o(tx_count),
        .push_acc_o(tx_push_acc), .pop_acc_o(tx_pop_acc)
    );

    assign rx_ready      = !rx_full;
    assign tx_valid      = !tx_empty;
    assign rx_flag       = !rx_empty;
    assign rx_head_mk    = rx_empty ? 8'h00 : ((MARK_BIT7 != 0) ? (rx_head | 8'h80) : rx_head);
    assign io_interrupt  = int_en_q && (rx_flag || tx_flag_q);
    assign io_data_avail = 1'b1;
    assign tx_overflow   = tx_overflow_q;

    // IOT bus response: pass AC through unless the keyboard side returns a byte.
    always_comb begin
        io_data_out = io_data_in;
        io_skip     = 1'b0;
        io_selected = 1'b0;
        if (rx_sel) begin
            io_selected = 1'b1;
            if (!kie) begin
                io_skip     = mb[0] && rx_flag;
                io_data_out = mb[2] ? {4'b0000, rx_head_mk} : 12'o0000;
            end
        end else if (tx_sel) begin
            io_selected = 1'b1;
            io_skip     = tsk ? (tx_flag_q || rx_flag) : (mb[0] && tx_flag_q);
        end
    end

    // Printer flag, interrupt enable and sticky overflow; flag set beats flag clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_flag_q     <= 1'b0;
            int_en_q      <= 1'b1;
            tx_overflow_q <= 1'b0;
            push_pend_q   <= 1'b0;
        end else begin
            push_pend_q <= tx_cpu_push;
            if (tx_pop_acc || (push_pend_q && !tx_full)) begin
                tx_flag_q <= 1'b1;
            end else if (tx_clr) begin
                tx_flag_q <= 1'b0;
            end
            if (kie) int_en_q <= io_data_in[0];
            if (tx_cpu_push && !tx_push_acc) tx_overflow_q <= 1'b1;
        end
    end
endmodule

// File: doc/pdp8_tt_fifo.md
Name: pdp8_tt_fifo

Overview:
- Parametrised PDP-8 console teleprinter/keyboard device: KL8-style IOT decode, receive and transmit byte FIFOs, a software interrupt-enable bit and configurable device codes.
- Sits between the CPU IOT bus and a byte-stream UART core. UART handshakes are plain valid/ready, so baud generation and serialisation stay outside this block.
- Multiple instances give additional serial lines.

Parameters:
- RX_DEV, 6'o03, device code for keyboard-side IOTs.
- TX_DEV, 6'o04, device code for printer-side IOTs.
- FIFO_AW, 4, log2 of FIFO depth; DEPTH = 2**FIFO_AW, applies to both FIFOs; legal 1..8.
- MARK_BIT7, 1, when 1 the received byte presented to the CPU has bit 7 forced to 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- iot  in  1  CPU executing IOT
- state  in  4  CPU major state; F1 = 4'b0001, lasts exactly one clk per IOT
- mb  in  12  instruction word; mb[2:0] is the function field
- io_select  in  6  device code from instruction
- io_data_in  in  12  AC value on IOT bus
- io_data_out  out  12  AC value returned
- io_selected  out  1  this device decoded the IOT
- io_skip  out  1  skip request
- io_interrupt  out  1  interrupt request
- io_data_avail  out  1  constant 1
- tx_data  out  8  byte to UART (TX FIFO head)
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  UART accepts byte
- rx_data  in  8  byte from UART
- rx_valid  in  1  UART has byte
- rx_ready  out  1  RX FIFO not full
- tx_overflow  out  1  sticky: CPU pushed to full TX FIFO
- rx_count  out  FIFO_AW+1  RX FIFO occupancy
- tx_count  out  FIFO_AW+1  TX FIFO occupancy

Behaviour:
- Decode is valid when iot && state==F1. It is combinational for io_* outputs; register effects occur at the posedge that ends F1.
- When not decoded: io_data_out = io_data_in, io_skip = 0, io_selected = 0.
- rx_flag = RX FIFO non-empty (level).
- tx_flag is a register: reset 0; cleared by IOT; set on any TX FIFO pop, and one clk after a CPU push if the TX FIFO is then not full. When set and clear occur in the same clk, set wins.
- int_en register: reset 1.
- io_interrupt = int_en && (rx_flag || tx_flag).
- RX_DEV IOT, io_selected=1:
  - mb[0]: io_skip = rx_flag.
  - mb[1]: pop RX FIFO if non-empty; no effect when empty.
  - mb[2]: io_data_out = {4'b0, head}, with head bit 7 forced to 1 if MARK_BIT7; head = 0 when empty. If mb[2]=0, io_data_out = 0.
  - Exception, mb[2:0]=3'b101 (KIE): int_en <= io_data_in[0]; io_data_out = io_data_in; no pop, no skip.
- TX_DEV IOT, io_selected=1, io_data_out = io_data_in:
  - mb[0]: io_skip = tx_flag.
  - mb[1]: clear tx_flag.
  - mb[2]: push io_data_in[7:0].
  - Exception, mb[2:0]=3'b101 (TSK): io_skip = tx_flag || rx_flag; nothing else.
  - mb=6 (clear+push) clears the flag now; the flag is re-set by the delayed push rule or a later pop.
- FIFOs:
  - Circular with FIFO_AW-bit pointers; count is FIFO_AW+1 bits; pointers wrap modulo DEPTH.
  - Pop occurs on valid&&ready (TX), CPU pop (RX).
  - Push occurs on rx_valid&&rx_ready (RX), CPU push (TX).
  - Push is accepted when not full, or when full with a pop in the same clk (count unchanged).
  - Simultaneous push and pop on empty: push accepted, pop ignored.
- TX push while full with no concurrent pop: byte dropped, tx_overflow <= 1. tx_overflow clears only on reset.
- rx_ready = !rx_full combinationally, so the UART holds its byte while the FIFO is full; no RX data is lost.
- Latency:
  - RX byte accepted at edge N: rx_flag=1 and interrupt visible after edge N.
  - TX push at edge N: tx_valid=1 after edge N.
- Reset mid-transfer: both FIFOs emptied, pointers=0, tx_flag=0, int_en=1, tx_overflow=0. Any byte being offered on rx_valid in the reset clk is not accepted.
- Reset values: io_interrupt=0, tx_valid=0, rx_ready=1, counts=0. Comb io_* outputs follow decode.

Test Plan:
- RX path: UART delivers 0x41 → io_interrupt=1. IOT 6031 → skip. IOT 6036 → io_data_out=12'o0301 (MARK_BIT7=1), rx_count 1→0, io_interrupt=0.
- RX full: deliver 17 bytes 0x00..0x10 with DEPTH=16 → rx_ready=0 after the 16th, the 17th is held. After one 6036 pop the 17th is accepted; popped order is 0x00..0x10.
- TX: 6046 with AC=0o101 → tx_valid=1, tx_data=0x41. One clk later tx_flag=1 (FIFO not full). Hold tx_ready=0 and push 16 more → the 17th is dropped and tx_overflow=1. Release tx_ready → 16 bytes emerge in order.
- Flag race: issue 6042 in the same clk as a TX pop → tx_flag stays 1.
- KIE: 6035 with AC=0 and rx_flag=1 → io_interrupt=0 while 6031 still skips. 6035 with AC=1 → io_interrupt=1. 6045 skips when either flag is set.
- Reset with 5 bytes in each FIFO → counts 0, tx_valid=0, rx_ready=1, int_en=1, no stale data on the next pop.
